mem_arb: RTL
============

Name: mem_arb

Overview:
- Arbiter and sequencer for the single shared SISC memory port.
- Serves two requesters: the instruction fetch path (read only) and the LOD/STR data path (read/write).
- Serialises their accesses, applies the memory's fixed read latency and returns read data with a one-cycle done pulse.
- Sits between the ctrl FSM/IR/PC datapath and the memory model; ctrl holds its fetch or mem state until done.

Parameters:
AW, 16, address width of memory and both requesters
DW, 32, data width
MEM_LAT, 1, cycles from issue cycle to valid mem_rdata (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_f  input  1  asynchronous active-low reset
if_req  input  1  fetch read request, level, held until if_done
if_addr  input  AW  fetch address (PC)
d_req  input  1  data request, level, held until d_done
d_we  input  1  data write (1) / read (0)
d_addr  input  AW  data address
d_wdata  input  DW  store data
if_gnt  output  1  fetch owns port (ISSUE..DONE)
d_gnt  output  1  data path owns port (ISSUE..DONE)
if_done  output  1  one-cycle pulse, fetch transaction complete
d_done  output  1  one-cycle pulse, data transaction complete
rdata  output  DW  registered read data, valid in done cycle, held until next read completes
busy  output  1  state != IDLE
mem_en  output  1  memory access strobe, ISSUE cycle only
mem_we  output  1  memory write strobe, ISSUE cycle only
mem_addr  output  AW  latched address
mem_wdata  output  DW  latched write data
mem_rdata  input  DW  memory read data

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE; 4-bit latency counter cnt; owner bit (0 = fetch, 1 = data); latched addr/wdata/we.
- Reset (rst_f low, async, effective immediately, including mid-transaction):
  - state = IDLE; all outputs 0; rdata = 0; cnt = 0; owner = 0.
  - The aborted transaction produces no done pulse.
- IDLE:
  - Arbitration: if any req is high, pick the winner, latch addr/wdata/we/owner at the clock edge and go to ISSUE.
  - Default priority: d_req beats if_req (data access belongs to the instruction in flight).
  - The fetch path always latches we = 0.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we = latched we; mem_addr/mem_wdata from latches.
  - Write: go to DONE.
  - Read: load cnt = MEM_LAT-1 and go to WAIT.
- WAIT:
  - If cnt != 0, decrement.
  - If cnt == 0, capture mem_rdata into rdata at the edge and go to DONE.
  - mem_rdata is therefore sampled MEM_LAT cycles after ISSUE.
- DONE (1 cycle): owner's done = 1, then IDLE. Writes leave rdata unchanged.
- Grants: if_gnt/d_gnt follow owner and are high in ISSUE, WAIT and DONE only.
- Latency from req seen in IDLE to done:
  - Read: 2+MEM_LAT cycles.
  - Write: 2 cycles.
  - Back-to-back transactions have one IDLE cycle between them.
- Requester rule: drop req on the edge that samples done. A req still high in the following IDLE cycle is a new request.
- req deasserted mid-transaction: ignored; the transaction completes and done still pulses.
- Input changes after the grant edge: ignored (values are latched).
- Simultaneous requests: the loser waits in IDLE and is served on the next arbitration with no loss of the request.

Optional Feature:
MEM_ARB_RR_EN
- Defined:
  - A last-served bit (reset value = data) tracks who was served last.
  - On simultaneous if_req and d_req, the requester not served last wins.
  - A single requester always wins.
  - The bit updates at each DONE.
- Undefined: fixed priority, data over fetch; the last-served bit does not exist.

Test Plan:
- Reset, MEM_LAT=1:
  - if_req=1, if_addr=0x0000, mem model returns 0x12345678.
  - Required: if_gnt high cycles 1–3; mem_en pulse in cycle 1 with mem_addr=0x0000; if_done and rdata=0x12345678 in cycle 3.
- Data write:
  - d_req=1, d_we=1, d_addr=0x0010, d_wdata=0xDEADBEEF.
  - Required: mem_en=mem_we=1 in the ISSUE cycle; d_done two cycles after the request; rdata unchanged; no if_done.
- Simultaneous if_req and d_req (d read of 0x0020):
  - Required: d served first and d_done fires; if_gnt rises two cycles later (one IDLE cycle between transactions).
  - With MEM_ARB_RR_EN and a second tie: fetch wins the first tie (last-served resets to data); data wins the second tie.
- MEM_LAT=3 read:
  - mem_rdata changes every cycle.
  - Required: rdata equals the value present 3 cycles after ISSUE; done in cycle 5.
- Reset mid-transaction:
  - Assert rst_f=0 during WAIT.
  - Required: all outputs 0 immediately; no done pulse; a new if_req after release completes normally.
- Early req drop:
  - Drop d_req in the ISSUE cycle.
  - Required: the transaction completes and d_done pulses.

Source files
------------

// File: rtl/mem_arb.sv
`timescale 1ns/1ps
// mem_arb: arbiter and sequencer for the shared memory port (instruction fetch vs LOD/STR data).
// Build option MEM_ARB_RR_EN: on simultaneous requests, the side not served last wins (default: data first).
//
// state | meaning
// IDLE  | port free, arbitrating between if_req and d_req
// ISSUE | one-cycle memory strobe with latched address/data/we
// WAIT  | read latency countdown, rdata captured when cnt hits 0
// DONE  | one-cycle done pulse to the owner, then back to IDLE
module mem_arb #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          if_gnt,
    output logic          d_gnt,
    output logic          if_done,
    output logic          d_done,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       owner;
    logic       pick_d;

`ifdef MEM_ARB_RR_EN
    logic last_d;
    assign pick_d = d_req & ~(if_req & last_d);
`else
    assign pick_d = d_req;
`endif

    // mem_we doubles as the latched write flag: it is still valid in ISSUE when the path is chosen.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            owner     <= 1'b0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            last_d    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state    <= ISSUE;
                        owner    <= pick_d;
                        if_gnt   <= ~pick_d;
                        d_gnt    <= pick_d;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_we   <= pick_d & d_we;
                        mem_addr <= pick_d ? d_addr : if_addr;
                        if (pick_d) begin
                            mem_wdata <= d_wdata;
                        end
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        state   <= DONE;
                        if_done <= ~owner;
                        d_done  <= owner;
                    end else begin
                        cnt   <= LAT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata   <= mem_rdata;
                        state   <= DONE;
                        if_done <= ~owner;
                        d_done  <= owner;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    if_done <= 1'b0;
                    d_done  <= 1'b0;
                    if_gnt  <= 1'b0;
                    d_gnt   <= 1'b0;
                    busy    <= 1'b0;
`ifdef MEM_ARB_RR_EN
                    last_d  <= owner;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
